// File: rtl/sqrt_rr_scheduler.sv
// rtl/sqrt_rr_scheduler.sv - round-robin shared bit-serial integer square root; SQRT_RR_SCHEDULER_REM_EN adds rsp_rem
module sqrt_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH/2-1:0]    rsp_root,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_exact,
`ifdef SQRT_RR_SCHEDULER_REM_EN
    output logic [WIDTH/2:0]      rsp_rem,
`endif
    output logic                  busy
);

    localparam int RW = WIDTH / 2;
    // Bit-index counter needs at least one bit even when RW == 1.
    localparam int BW = (RW > 1) ? $clog2(RW) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [WIDTH-1:0] opnd;
    logic [RW-1:0]    root;
    logic [BW-1:0]    bitk;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   cand;
    logic             found;
    logic             accept;

    logic [RW-1:0]    mask;
    logic [RW-1:0]    trial;
    logic [WIDTH-1:0] trial_w;
    logic [WIDTH-1:0] trial_sq;
    logic [RW-1:0]    root_nx;
    logic [WIDTH-1:0] root_nx_w;
    logic [WIDTH-1:0] root_sq;

    // Round-robin search: first valid requester strictly after the last one served.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(ptr) + off) % NREQ);
            if (!found && req_valid[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

    // Grants are only offered while idle and out of reset.
    assign req_ready = (state == ST_IDLE && rst_n) ? gnt : '0;
    assign accept    = |(req_valid & req_ready);
    assign busy      = (state == ST_CALC) || (state == ST_DONE);

    // One restoring-root step: keep bit k if the trial root squared still fits under n.
    // trial < 2^RW, so its square always fits in WIDTH bits.
    assign mask      = RW'(1) << bitk;
    assign trial     = root | mask;
    assign trial_w   = WIDTH'(trial);
    assign trial_sq  = trial_w * trial_w;
    assign root_nx   = (trial_sq <= opnd) ? trial : root;
    assign root_nx_w = WIDTH'(root_nx);
    assign root_sq   = root_nx_w * root_nx_w;

    // Arbitration, iteration and response-hold sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= IDW'(NREQ - 1);
            opnd      <= '0;
            root      <= '0;
            bitk      <= '0;
            rsp_valid <= 1'b0;
            rsp_root  <= '0;
            rsp_id    <= '0;
            rsp_exact <= 1'b0;
`ifdef SQRT_RR_SCHEDULER_REM_EN
            rsp_rem   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        opnd   <= req_data[int'(gnt_idx)*WIDTH +: WIDTH];
                        rsp_id <= gnt_idx;
                        ptr    <= gnt_idx;
                        root   <= '0;
                        bitk   <= BW'(RW - 1);
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    root <= root_nx;
                    if (bitk == '0) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_root  <= root_nx;
                        rsp_exact <= (root_sq == opnd);
`ifdef SQRT_RR_SCHEDULER_REM_EN
                        rsp_rem   <= (RW+1)'(opnd - root_sq);
`endif
                    end else begin
                        bitk <= bitk - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE here means the next grant appears one cycle later.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// tb/tb_sqrt_rr_scheduler.sv - scoreboard bench for sqrt_rr_scheduler
module tb_sqrt_rr_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int RW    = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [RW-1:0]         rsp_root;
    logic [1:0]            rsp_id;
    logic                  rsp_exact;
`ifdef SQRT_RR_SCHEDULER_REM_EN
    logic [RW:0]           rsp_rem;
`endif
    logic                  busy;

    sqrt_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_root  (rsp_root),
        .rsp_id    (rsp_id),
        .rsp_exact (rsp_exact),
`ifdef SQRT_RR_SCHEDULER_REM_EN
        .rsp_rem   (rsp_rem),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int root;
        int exact;
        int rem;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   exp_root  [NREQ];
    int   exp_exact [NREQ];
    int   exp_rem   [NREQ];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic prev_valid = 1'b0;
    exp_t e_obs;
    exp_t e_mon;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Accept observer: push the hand-computed expectation of the granted requester.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e_obs.id    = i;
                    e_obs.root  = exp_root[i];
                    e_obs.exact = exp_exact[i];
                    e_obs.rem   = exp_rem[i];
                    e_obs.acc   = cyc + 1;
                    sb.push_back(e_obs);
                    grant_log.push_back(i);
                end
            end
        end
    end

    // Response monitor: latency on rising valid, field compare on handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid && !prev_valid && sb.size() > 0)
                chk("latency", cyc - sb[0].acc, RW);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", sb.size(), 1);
                end else begin
                    e_mon = sb.pop_front();
                    chk("rsp_id", rsp_id, e_mon.id);
                    chk("rsp_root", rsp_root, e_mon.root);
                    chk("rsp_exact", rsp_exact, e_mon.exact);
`ifdef SQRT_RR_SCHEDULER_REM_EN
                    chk("rsp_rem", rsp_rem, e_mon.rem);
`endif
                end
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic set_req(input int i, input int data, input int root, input int exact, input int rem);
        req_data[i*WIDTH +: WIDTH] = WIDTH'(data);
        exp_root[i]  = root;
        exp_exact[i] = exact;
        exp_rem[i]   = rem;
    endtask

    // Returns just after the accepting edge; w = idle negedges before the grant.
    task automatic wait_grant(input int idx, output int w);
        w = 0;
        @(negedge clk);
        while (!req_ready[idx] && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("grant", req_ready, 32'(1) << idx);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", (sb.size() == 0 && !busy), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic single(input int idx, input int data, input int root, input int exact, input int rem);
        int w;
        set_req(idx, data, root, exact, rem);
        req_valid = NREQ'(1) << idx;
        wait_grant(idx, w);
        chk("grant_wait", w, 0);
        req_valid = '0;
        drain();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, rsp_valid, 0);
        chk({tag, "_root"}, rsp_root, 0);
        chk({tag, "_id"}, rsp_id, 0);
        chk({tag, "_exact"}, rsp_exact, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, req_ready, 0);
`ifdef SQRT_RR_SCHEDULER_REM_EN
        chk({tag, "_rem"}, rsp_rem, 0);
`endif
    endtask

    initial begin
        int t;
        int w;
        int order [5];
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 1, 0);
        #1 rst_n = 1'b0;
        #1;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single request on requester 2: 144 -> 12 exact.
        rsp_ready = 1'b1;
        single(2, 144, 12, 1, 0);

        // Round-robin with all requesters continuously valid.
        do_reset();
        grant_log.delete();
        set_req(0, 0, 0, 1, 0);
        set_req(1, 1, 1, 1, 0);
        set_req(2, 4, 2, 1, 0);
        set_req(3, 9, 3, 1, 0);
        req_valid = 4'b1111;
        t = 0;
        while (grant_log.size() < 5 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        req_valid = '0;
        drain();
        order = '{0, 1, 2, 3, 0};
        chk("rr_count", grant_log.size() >= 5, 1);
        if (grant_log.size() >= 5)
            for (int k = 0; k < 5; k++) chk("rr_order", grant_log[k], order[k]);

        // Backpressure: 200 -> 14 rem 4, held while rsp_ready low.
        set_req(1, 200, 14, 0, 4);
        set_req(2, 4, 2, 1, 0);
        set_req(3, 9, 3, 1, 0);
        rsp_ready = 1'b0;
        req_valid = 4'b1110;
        wait_grant(1, w);
        t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_rise", rsp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_valid", rsp_valid, 1);
            chk("bp_hold_root", rsp_root, 14);
            chk("bp_hold_exact", rsp_exact, 0);
`ifdef SQRT_RR_SCHEDULER_REM_EN
            chk("bp_hold_rem", rsp_rem, 4);
`endif
            chk("bp_hold_ready", req_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_ready", req_ready, 0);
        @(negedge clk);
        chk("bp_next_grant", req_ready, 4'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();

        // Boundary radicands.
        single(0, 0, 0, 1, 0);
        single(0, 'hFFFF, 'hFF, 0, 'h1FE);
        single(0, 'hFE01, 'hFF, 1, 0);
        single(0, 'h4000, 'h80, 1, 0);

        // Reset three edges into CALC with requesters 1 and 3 pending.
        set_req(2, 144, 12, 1, 0);
        req_valid = 4'b0100;
        wait_grant(2, w);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        set_req(1, 9, 3, 1, 0);
        set_req(3, 4, 2, 1, 0);
        req_valid = 4'b1010;
        #1;
        chk_zero("midreset");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_first_grant", req_ready, 4'b0010);
        @(posedge clk);
        #1;
        req_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("midreset_no_rsp", rsp_valid, 0);
        end
        wait_grant(3, w);
        req_valid = '0;
        drain();

        // Requester 1 drops valid while requester 0 is served.
        grant_log.delete();
        set_req(0, 16, 4, 1, 0);
        set_req(1, 25, 5, 1, 0);
        req_valid = 4'b0011;
        wait_grant(0, w);
        set_req(3, 49, 7, 1, 0);
        req_valid = 4'b1000;
        wait_grant(3, w);
        req_valid = '0;
        drain();
        chk("skip_count", grant_log.size(), 2);
        for (int k = 0; k < grant_log.size(); k++)
            chk("skip_never_1", grant_log[k] == 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sqrt_rr_scheduler.md
Name: sqrt_rr_scheduler

Overview:
- Shares one iterative integer square-root datapath between NREQ requesters.
- Each requester presents a WIDTH-bit radicand on a valid/ready port. A round-robin arbiter grants one request at a time.
- The datapath computes floor(sqrt(n)) one result bit per clock, MSB first.
- One response port returns the root, the winning requester's index and an exactness flag, with valid/ready backpressure.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 16, radicand width; must be even. Root width is RW = WIDTH/2.
- IDW, $clog2(NREQ), width of the requester index field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_data  in  NREQ*WIDTH  radicands; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot (or zero) grant/accept.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_root  out  RW  floor(sqrt(n)).
- rsp_id  out  IDW  index of the requester that was served.
- rsp_exact  out  1  1 when root*root == n.
- busy  out  1  high in CALC or DONE.

Behaviour:
- States:
  - IDLE: waiting for a request.
  - CALC: computing; lasts exactly RW cycles.
  - DONE: holding the result.
- Reset (async, rst_n low), state forced immediately:
  - state=IDLE, rsp_valid=0, rsp_root=0, rsp_id=0, rsp_exact=0, busy=0, req_ready=0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
  - Internal operand/root/bit-index registers = 0.
- Grant rules:
  - req_ready is combinational. req_ready[i]=1 only when state==IDLE, rst_n high, and i is the first asserted req_valid searching upward from pointer+1 (mod NREQ).
  - At most one bit of req_ready is high.
  - Accept = req_valid[g] && req_ready[g] at a rising edge. On accept: latch req_data[g], rsp_id<=g, pointer<=g, root<=0, bit index<=RW-1, go to CALC.
  - Requesters must hold valid and data stable until accepted. A requester that drops valid before accept is simply skipped.
- CALC, one edge per bit k, from RW-1 down to 0:
  - trial = root | (1<<k).
  - If trial*trial <= n, set root[k]=1.
  - The product is computed at WIDTH bits unsigned (cannot overflow because trial < 2^RW).
  - After the k=0 edge: go to DONE, rsp_root<=root, rsp_exact<=(root*root==n), rsp_valid<=1.
- Latency:
  - rsp_valid rises exactly RW clock edges after the accepting edge (8 for WIDTH=16).
  - rsp_valid, rsp_root, rsp_id and rsp_exact are registered outputs.
- DONE:
  - rsp_valid, rsp_root, rsp_id and rsp_exact are held stable until rsp_ready.
  - On the edge where rsp_valid && rsp_ready: rsp_valid<=0, go to IDLE.
  - The next grant is no earlier than the following cycle; there is no same-cycle re-accept.
  - rsp_root/rsp_id/rsp_exact keep their last values after the handshake.
- Fairness: the served requester becomes lowest priority. With all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
- Boundaries:
  - n=0 → root 0, exact=1.
  - n=2^WIDTH-1 → root 2^RW-1, exact=0.
  - req_valid changes during CALC/DONE are ignored.
  - rsp_ready high in IDLE/CALC has no effect.
- Reset mid-operation: the in-flight request is discarded, no response is produced, and arbitration restarts at requester 0.

Optional Feature:
- Macro: SQRT_RR_SCHEDULER_REM_EN.
- When defined:
  - Adds output port rsp_rem, width RW+1, = n - root*root. Maximum value is 2*root, which fits in RW+1 bits.
  - rsp_rem is registered with the other response fields and has the same timing and hold rules.
  - rsp_rem resets to 0.
  - rsp_exact equals (rsp_rem==0).
- When undefined: the port does not exist and there is no remainder logic. All other behaviour is identical.

Test Plan:
- Single request: req_valid[2]=1, data 144. Required response: req_ready[2] high in that cycle; rsp_valid exactly 8 edges later with root=12, id=2, exact=1; rsp_rem=0 when REM_EN.
- Round-robin: all 4 requesters valid continuously with data 0,1,4,9 and rsp_ready tied high. Required grant order after reset is 0,1,2,3,0. Required roots are 0,1,2,3, all with exact=1.
- Backpressure: n=200 with rsp_ready held low for 5 cycles after rsp_valid. Required: rsp_valid stays high with root=14, exact=0 (rem=4 when REM_EN) stable throughout; req_ready stays 0 while other requesters are valid; after rsp_ready goes high, the next grant comes one cycle later.
- Boundaries:
  - n=0 → root 0, exact=1.
  - n=0xFFFF → root 0xFF, exact=0, rem 0x1FE.
  - n=0xFE01 → root 0xFF, exact=1.
  - n=0x4000 → root 0x80, exact=1.
- Reset mid-CALC: assert rst_n low 3 edges after accept. Required: all outputs zero immediately; no rsp_valid after release; with requesters 1 and 3 pending, the first grant goes to 1.
- Skip on drop: requester 1 drops valid while requester 0 is being served. Required: the next grant goes to the next valid requester; requester 1 is never granted or reported.
